phe_sampler_x4: RTL and testbench

PHE_SAMPLER_X4 -- requirements
Module: phe_sampler_x4

---
 rtl/fod_pkg.sv | 7 +
 rtl/phe_therm_dec.sv | 27 ++
 rtl/phe_sampler_x4.sv | 115 +++++++++++
 tb/tb_phe_sampler_x4.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fod_pkg.sv
// Shared constants and types for the multi-phase error sampler.
package fod_pkg;
  localparam int unsigned MP_SEG_BIN = 3;
  localparam int unsigned MP_SEG     = 1 << MP_SEG_BIN;
  localparam int unsigned LANES      = 4;
  typedef logic [MP_SEG_BIN-1:0] phe_code_t;
endpackage

// File: rtl/phe_therm_dec.sv
// Circular thermometer decoder: returns the rising-boundary index and whether
// exactly one such boundary exists.
module phe_therm_dec #(
  parameter int unsigned CODE_W = 3
) (
  input  logic [(1<<CODE_W)-1:0] psamp_i,
  output logic [CODE_W-1:0]      code_c_o,
  output logic                   valid_c_o
);

  localparam int unsigned N = 1 << CODE_W;

  logic [CODE_W:0] n_rise;

  always_comb begin
    code_c_o = '0;
    n_rise   = '0;
    for (int i = 0; i < N; i++) begin
      if (psamp_i[i] && !psamp_i[(i + N - 1) % N]) begin
        code_c_o = CODE_W'(i);
        n_rise   = n_rise + (CODE_W+1)'(1);
      end
    end
    valid_c_o = (n_rise == (CODE_W+1)'(1));
  end

endmodule

// File: rtl/phe_sampler_x4.sv
// Samples the multi-phase word, decodes it to a phase code and packs four
// consecutive EN-qualified codes into one frame, counting invalid samples.
module phe_sampler_x4 #(
  parameter int unsigned MP_SEG_BIN = fod_pkg::MP_SEG_BIN,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                                 CLK,
  input  logic                                 NARST,
  input  logic                                 EN,
  input  logic [(1<<MP_SEG_BIN)-1:0]           PSAMP,
  input  logic                                 ERR_CLR,
  output logic [fod_pkg::LANES*MP_SEG_BIN-1:0] PHE_X4,
  output logic                                 PHE_VLD,
  output logic                                 PHE_ERR,
  output logic [ERR_W-1:0]                     ERR_CNT
);

  localparam int unsigned NPH   = 1 << MP_SEG_BIN;
  localparam int unsigned CW    = MP_SEG_BIN;
  localparam int unsigned LANES = fod_pkg::LANES;
  localparam int unsigned FW    = LANES * CW;

  logic [NPH-1:0]   s1_q, s1_d;
  logic             en1_q, en1_d;
  logic [CW-1:0]    code2_q, code2_d;
  logic [CW-1:0]    last_q, last_d;
  logic             err2_q, err2_d;
  logic             en2_q, en2_d;
  logic [1:0]       slot_q, slot_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic             rdy_q, rdy_d;
  logic [FW-1:0]    x4_q, x4_d;
  logic             vld_q, vld_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic [CW-1:0]    dec_code;
  logic             dec_valid;

  phe_therm_dec #(.CODE_W(CW)) u_dec (
    .psamp_i   (s1_q),
    .code_c_o  (dec_code),
    .valid_c_o (dec_valid)
  );

  // Next-state: capture, decode/hold, frame collection, output load, error count
  always_comb begin
    s1_d    = PSAMP;
    en1_d   = EN;
    en2_d   = en1_q;
    err2_d  = !dec_valid;
    code2_d = dec_valid ? dec_code : last_q;
    last_d  = code2_d;
    slot_d  = slot_q;
    frame_d = frame_q;
    rdy_d   = 1'b0;
    x4_d    = x4_q;
    vld_d   = rdy_q;
    cnt_d   = cnt_q;

    if (en2_q) begin
      for (int k = 0; k < LANES; k++) begin
        if (slot_q == 2'(k)) frame_d[k*CW +: CW] = code2_q;
      end
      slot_d = slot_q + 2'd1;
      rdy_d  = (slot_q == 2'd3);
    end else begin
      slot_d = 2'd0;
    end

    // Frame register lags collection by one edge so slot 3 is already stored
    if (rdy_q) x4_d = frame_q;

    if (ERR_CLR) begin
      cnt_d = '0;
    end else if (en2_q && err2_q && (cnt_q != {ERR_W{1'b1}})) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      s1_q    <= '0;
      en1_q   <= 1'b0;
      code2_q <= '0;
      last_q  <= '0;
      err2_q  <= 1'b0;
      en2_q   <= 1'b0;
      slot_q  <= 2'd0;
      frame_q <= '0;
      rdy_q   <= 1'b0;
      x4_q    <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      en1_q   <= en1_d;
      code2_q <= code2_d;
      last_q  <= last_d;
      err2_q  <= err2_d;
      en2_q   <= en2_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      rdy_q   <= rdy_d;
      x4_q    <= x4_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PHE_X4  = x4_q;
  assign PHE_VLD = vld_q;
  assign PHE_ERR = err2_q;
  assign ERR_CNT = cnt_q;

endmodule

// File: tb/tb_phe_sampler_x4.sv
// Randomised and directed bench for phe_sampler_x4 with a history-based
// reference model of decode, framing and error counting.
module tb_phe_sampler_x4;

  localparam int DEPTH = 4096;

  logic        CLK = 1'b0;
  logic        NARST;
  logic        EN;
  logic [7:0]  PSAMP;
  logic        ERR_CLR;
  logic [11:0] PHE_X4;
  logic        PHE_VLD;
  logic        PHE_ERR;
  logic [7:0]  ERR_CNT;

  phe_sampler_x4 #(.MP_SEG_BIN(3), .ERR_W(8)) dut (
    .CLK     (CLK),
    .NARST   (NARST),
    .EN      (EN),
    .PSAMP   (PSAMP),
    .ERR_CLR (ERR_CLR),
    .PHE_X4  (PHE_X4),
    .PHE_VLD (PHE_VLD),
    .PHE_ERR (PHE_ERR),
    .ERR_CNT (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [15:0] d;
    d = {v, v} << s;
    return d[15:8];
  endfunction

  // A valid word is one circular run of ones (not empty, not full); code = run start
  function automatic int ref_code(input logic [7:0] w);
    for (int i = 0; i < 8; i++)
      for (int l = 1; l < 8; l++)
        if (w == rotl8(8'((1 << l) - 1), i)) return i;
    return -1;
  endfunction

  // Per-edge history of what the DUT captured
  logic [7:0] ps_h   [DEPTH];
  bit         en_h   [DEPTH];
  bit         clr_h  [DEPTH];
  int         code_h [DEPTH];
  int         run_h  [DEPTH];
  int         cyc = 8;
  int         m_cnt = 0;
  logic [11:0] m_x4 = '0;
  bit         e_vld;
  bit         e_err;

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      ps_h[k] = '0; en_h[k] = 0; clr_h[k] = 0; code_h[k] = 0; run_h[k] = 0;
    end
    forever begin
      @(posedge CLK);
      if (cyc < DEPTH) begin
        int c;
        int j;
        if (!NARST) begin
          ps_h[cyc] = '0; en_h[cyc] = 0; clr_h[cyc] = 0;
          code_h[cyc] = 0; run_h[cyc] = 0;
          en_h[cyc-1] = 0;
          m_cnt = 0; m_x4 = '0; e_vld = 0; e_err = 0;
        end else begin
          ps_h[cyc]  = PSAMP;
          en_h[cyc]  = EN;
          clr_h[cyc] = ERR_CLR;
          c = ref_code(PSAMP);
          code_h[cyc] = (c >= 0) ? c : code_h[cyc-1];
          run_h[cyc]  = EN ? run_h[cyc-1] + 1 : 0;
          e_err = (ref_code(ps_h[cyc-1]) < 0);
          j = cyc - 2;
          if (clr_h[cyc]) m_cnt = 0;
          else if (en_h[j] && ref_code(ps_h[j]) < 0 && m_cnt < 255) m_cnt++;
          j = cyc - 3;
          e_vld = en_h[j] && run_h[j] > 0 && (run_h[j] % 4) == 0;
          if (e_vld)
            m_x4 = {3'(code_h[j]), 3'(code_h[j-1]), 3'(code_h[j-2]), 3'(code_h[j-3])};
        end
        #1;
        chk("model_phe_x4", PHE_X4, m_x4);
        chk("model_phe_vld", PHE_VLD, e_vld);
        chk("model_phe_err", PHE_ERR, e_err);
        chk("model_err_cnt", ERR_CNT, m_cnt);
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (PHE_VLD) vld_seen++;
    end
  end

  task automatic drive(input logic [7:0] ps, input bit e, input bit c);
    @(negedge CLK);
    PSAMP = ps; EN = e; ERR_CLR = c;
  endtask

  function automatic logic [7:0] th(input int k);
    return rotl8(8'h0F, k);
  endfunction

  initial begin
    int lat;
    NARST = 1'b0; EN = 1'b0; PSAMP = '0; ERR_CLR = 1'b0;
    @(posedge CLK); #2;
    chk("reset_x4", PHE_X4, 0);
    chk("reset_vld", PHE_VLD, 0);
    chk("reset_err", PHE_ERR, 0);
    chk("reset_cnt", ERR_CNT, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); NARST = 1'b1;

    // Two frames of codes 0,1,2,3
    vld_seen = 0;
    repeat (2) for (int k = 0; k < 4; k++) drive(th(k), 1, 0);
    repeat (6) drive(th(0), 0, 0);
    chk("frame_0123", PHE_X4, 12'h688);
    chk("frame_0123_vld_count", vld_seen, 2);
    chk("frame_0123_cnt", ERR_CNT, 0);

    // Wrap-around thermometer words
    drive(8'b00001111, 1, 0);
    drive(8'b00011110, 1, 0);
    drive(8'b10000111, 1, 0);
    drive(8'b11000011, 1, 0);
    repeat (6) drive(th(0), 0, 0);
    chk("frame_wrap_words", PHE_X4, 12'hDC8);
    chk("frame_wrap_cnt", ERR_CNT, 0);

    // Bubble, all-zero, all-one hold the last valid code and count
    drive(th(0), 0, 1);
    drive(8'b00111100, 1, 0);
    drive(8'b00101111, 1, 0);
    drive(8'h00, 1, 0);
    drive(8'hFF, 1, 0);
    repeat (6) drive(th(0), 0, 0);
    chk("frame_invalid_hold", PHE_X4, 12'h492);
    chk("invalid_count", ERR_CNT, 3);

    // Partial frame dropped, next frame realigned to slot 0
    vld_seen = 0;
    drive(th(1), 1, 0);
    drive(th(2), 1, 0);
    drive(th(5), 0, 0);
    repeat (4) drive(th(3), 1, 0);
    repeat (6) drive(th(0), 0, 0);
    chk("partial_vld_count", vld_seen, 1);
    chk("realigned_frame", PHE_X4, 12'h6DB);

    // Saturation and clear-over-increment
    repeat (300) drive(8'h00, 1, 0);
    repeat (4) drive(th(0), 0, 0);
    chk("cnt_saturated", ERR_CNT, 255);
    repeat (3) drive(8'h00, 1, 0);
    drive(8'h00, 0, 1);
    @(posedge CLK); #1;
    chk("clr_beats_inc", ERR_CNT, 0);
    drive(th(0), 0, 0);

    // Reset mid-frame
    drive(th(1), 1, 0);
    drive(th(2), 1, 0);
    @(negedge CLK); #2;
    NARST = 1'b0; EN = 1'b0;
    #1;
    chk("midrst_x4", PHE_X4, 0);
    chk("midrst_vld", PHE_VLD, 0);
    chk("midrst_err", PHE_ERR, 0);
    chk("midrst_cnt", ERR_CNT, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    NARST = 1'b1; EN = 1'b1; PSAMP = th(4);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (PHE_VLD && lat == 0) lat = k;
    end
    chk("rst_to_first_vld", lat, 7);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] w;
      if ($urandom_range(0, 99) < 70)
        w = rotl8(8'((1 << $urandom_range(1, 7)) - 1), int'($urandom_range(0, 7)));
      else
        w = 8'($urandom);
      drive(w, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
    end
    repeat (6) drive(th(0), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
